// File: rtl/disp_pixout.sv
// Pixel output stage behind syncgen: pops RGB from the VRAM read FIFO and drives the panel
// with RGB/DE/HSYNC/VSYNC all delayed two DCLK, blanking the frame on underflow.
module disp_pixout #(
    parameter int unsigned HACT  = 640,
    parameter int unsigned VACT  = 480,
    parameter logic [23:0] BLANK = 24'h000000
) (
    input  logic        DCLK,
    input  logic        DRST,
    input  logic        DISP_ON,
    input  logic        DSP_preDE,
    input  logic        DSP_HSYNC_X,
    input  logic        DSP_VSYNC_X,
    input  logic        VRSTART,
    input  logic [23:0] FIFO_DOUT,
    input  logic        FIFO_EMPTY,
    input  logic        CLR_ERR,
    output logic        FIFO_RD,
    output logic [7:0]  DSP_R,
    output logic [7:0]  DSP_G,
    output logic [7:0]  DSP_B,
    output logic        DSP_DE,
    output logic        DSP_HSYNC_XO,
    output logic        DSP_VSYNC_XO,
    output logic        UNDERFLOW,
    output logic        FRAME_ERR,
    output logic        FRAME_DONE,
    output logic [1:0]  DBG_STATE
);

    localparam logic [19:0] FPIX = 20'(HACT * VACT);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_BLANKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] pixcnt_q, pixcnt_d;
    logic        vr_d1_q;
    logic        underflow_q, underflow_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_done_q, frame_done_d;
    logic        de_d1_q, de_d2_q;
    logic        tag_d1_q;
    logic [23:0] rgb_q, rgb_d;
    logic [1:0]  hs_q, vs_q;

    logic        vr_rise;
    logic        rd_en;
    logic [19:0] pixcnt_inc;
    logic        set_uf, set_fe;

    assign vr_rise    = VRSTART & ~vr_d1_q;
    // Reads are suppressed during the reset cycle so a mid-frame reset never pops a word.
    assign rd_en      = (state_q == ST_ACTIVE) & DSP_preDE & ~FIFO_EMPTY & DISP_ON & ~DRST;
    assign pixcnt_inc = pixcnt_q + 20'd1;

    always_comb begin
        state_d      = state_q;
        pixcnt_d     = pixcnt_q;
        set_uf       = 1'b0;
        set_fe       = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (vr_rise && DISP_ON) begin
                    state_d  = ST_ACTIVE;
                    pixcnt_d = 20'd0;
                end
            end
            ST_ACTIVE: begin
                if (!DISP_ON) begin
                    state_d = ST_WAIT;
                end else begin
                    if (rd_en) begin
                        pixcnt_d = pixcnt_inc;
                    end
                    // Completion outranks an early VRSTART landing on the same cycle.
                    if (DSP_preDE && FIFO_EMPTY) begin
                        set_uf  = 1'b1;
                        state_d = ST_BLANKED;
                    end else if (rd_en && (pixcnt_inc == FPIX)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_WAIT;
                    end else if (vr_rise) begin
                        set_fe   = 1'b1;
                        pixcnt_d = rd_en ? 20'd1 : 20'd0;
                    end
                end
            end
            ST_BLANKED: begin
                if (!DISP_ON) begin
                    state_d = ST_WAIT;
                end else if (vr_rise) begin
                    state_d  = ST_ACTIVE;
                    pixcnt_d = 20'd0;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_comb begin
        underflow_d = underflow_q;
        frame_err_d = frame_err_q;
        if (set_uf) begin
            underflow_d = 1'b1;
        end else if (CLR_ERR) begin
            underflow_d = 1'b0;
        end
        if (set_fe) begin
            frame_err_d = 1'b1;
        end else if (CLR_ERR) begin
            frame_err_d = 1'b0;
        end
    end

    // FIFO_DOUT is valid the cycle after the pop, so the tag selects data or BLANK one cycle later.
    assign rgb_d = tag_d1_q ? FIFO_DOUT : BLANK;

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            state_q      <= ST_WAIT;
            pixcnt_q     <= 20'd0;
            vr_d1_q      <= 1'b0;
            underflow_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            de_d1_q      <= 1'b0;
            de_d2_q      <= 1'b0;
            tag_d1_q     <= 1'b0;
            rgb_q        <= BLANK;
            hs_q         <= 2'b11;
            vs_q         <= 2'b11;
        end else begin
            state_q      <= state_d;
            pixcnt_q     <= pixcnt_d;
            vr_d1_q      <= VRSTART;
            underflow_q  <= underflow_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
            de_d1_q      <= DSP_preDE;
            de_d2_q      <= de_d1_q;
            tag_d1_q     <= rd_en;
            rgb_q        <= rgb_d;
            hs_q         <= {hs_q[0], DSP_HSYNC_X};
            vs_q         <= {vs_q[0], DSP_VSYNC_X};
        end
    end

    assign FIFO_RD      = rd_en;
    assign DSP_R        = rgb_q[23:16];
    assign DSP_G        = rgb_q[15:8];
    assign DSP_B        = rgb_q[7:0];
    assign DSP_DE       = de_d2_q;
    assign DSP_HSYNC_XO = hs_q[1];
    assign DSP_VSYNC_XO = vs_q[1];
    assign UNDERFLOW    = underflow_q;
    assign FRAME_ERR    = frame_err_q;
    assign FRAME_DONE   = frame_done_q;
    assign DBG_STATE    = state_q;

endmodule
